// File: rtl/score_display_if.sv
// Beam/score bus between the frame timing, score counter and score renderer.
interface score_display_if;
   logic        game_tick;
   logic [15:0] score;
   logic [9:0]  hpos;
   logic [9:0]  vpos;
   logic        display_on;
   logic        pixel_on;

   modport master (
      output game_tick, score, hpos, vpos, display_on,
      input  pixel_on
   );

   modport slave (
      input  game_tick, score, hpos, vpos, display_on,
      output pixel_on
   );
endinterface

// File: rtl/score_display.sv
// Draws the frame-latched 4-digit BCD score inside a fixed screen box,
// two-stage pipelined from beam position to pixel_on, leading zeros blanked.
module score_display #(
   parameter int X0          = 560,
   parameter int Y0          = 16,
   parameter int SCALE_SHIFT = 2
) (
   input logic             clk,
   input logic             rst_n,
   score_display_if.slave  bus
);

   localparam int CW = 5 << SCALE_SHIFT;
   localparam int H  = 5 << SCALE_SHIFT;
   localparam logic [31:0] XL  = 32'(X0);
   localparam logic [31:0] XH  = 32'(X0 + 4 * CW);
   localparam logic [31:0] YL  = 32'(Y0);
   localparam logic [31:0] YH  = 32'(Y0 + H);
   localparam logic [31:0] CW1 = 32'(CW);
   localparam logic [31:0] CW2 = 32'(2 * CW);
   localparam logic [31:0] CW3 = 32'(3 * CW);

   logic        tick_q;
   logic [15:0] snap_q;

   logic        box_d, box_q;
   logic        de_q;
   logic [1:0]  k_d, k_q;
   logic [2:0]  fc_d, fc_q;
   logic [2:0]  fr_d, fr_q;
   logic        pixel_d, pixel_q;

   logic [31:0] hx, vy, rel_x, rel_y, off_x;
   logic [3:0]  digit;
   logic [3:0]  row;
   logic        lit;
   logic        blank;

   // 4x5 glyph, row 0 in the top nibble; non-decimal nibbles draw nothing
   function automatic logic [3:0] font_row(input logic [3:0] d,
                                           input logic [2:0] r);
      logic [19:0] g;
      logic [3:0]  n;
      g = 20'h0;
      n = 4'h0;
      case (d)
         4'd0:    g = 20'hF999F;
         4'd1:    g = 20'h26227;
         4'd2:    g = 20'hF1F8F;
         4'd3:    g = 20'hF171F;
         4'd4:    g = 20'h99F11;
         4'd5:    g = 20'hF8F1F;
         4'd6:    g = 20'hF8F9F;
         4'd7:    g = 20'hF1244;
         4'd8:    g = 20'hF9F9F;
         4'd9:    g = 20'hF9F1F;
         default: g = 20'h0;
      endcase
      case (r)
         3'd0:    n = g[19:16];
         3'd1:    n = g[15:12];
         3'd2:    n = g[11:8];
         3'd3:    n = g[7:4];
         3'd4:    n = g[3:0];
         default: n = 4'h0;
      endcase
      return n;
   endfunction

   // snapshot one cycle after the tick to catch the counter's new value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_q <= 1'b0;
         snap_q <= 16'h0;
      end else begin
         tick_q <= bus.game_tick;
         if (tick_q) snap_q <= bus.score;
      end
   end

   assign hx    = 32'(bus.hpos);
   assign vy    = 32'(bus.vpos);
   assign rel_x = hx - XL;
   assign rel_y = vy - YL;
   assign box_d = (hx >= XL) && (hx < XH) && (vy >= YL) && (vy < YH);

   always_comb begin
      k_d   = 2'd3;
      off_x = rel_x - CW3;
      unique case (1'b1)
         (rel_x < CW1): begin
            k_d   = 2'd0;
            off_x = rel_x;
         end
         (rel_x >= CW1) && (rel_x < CW2): begin
            k_d   = 2'd1;
            off_x = rel_x - CW1;
         end
         (rel_x >= CW2) && (rel_x < CW3): begin
            k_d   = 2'd2;
            off_x = rel_x - CW2;
         end
         (rel_x >= CW3): begin
            k_d   = 2'd3;
            off_x = rel_x - CW3;
         end
      endcase
   end

   assign fc_d = 3'(off_x >> SCALE_SHIFT);
   assign fr_d = 3'(rel_y >> SCALE_SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         box_q <= 1'b0;
         de_q  <= 1'b0;
         k_q   <= 2'd0;
         fc_q  <= 3'd0;
         fr_q  <= 3'd0;
      end else begin
         box_q <= box_d;
         de_q  <= bus.display_on;
         k_q   <= k_d;
         fc_q  <= fc_d;
         fr_q  <= fr_d;
      end
   end

   always_comb begin
      digit = snap_q[3:0];
      blank = 1'b0;
      case (k_q)
         2'd0: begin
            digit = snap_q[15:12];
            blank = (snap_q[15:12] == 4'h0);
         end
         2'd1: begin
            digit = snap_q[11:8];
            blank = (snap_q[15:8] == 8'h0);
         end
         2'd2: begin
            digit = snap_q[7:4];
            blank = (snap_q[15:4] == 12'h0);
         end
         default: begin
            digit = snap_q[3:0];
            blank = 1'b0;
         end
      endcase
   end

   assign row = font_row(digit, fr_q);

   always_comb begin
      lit = 1'b0;
      if (fc_q < 3'd4) lit = row[2'(3'd3 - fc_q)];
   end

   assign pixel_d = de_q & box_q & lit & ~blank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pixel_q <= 1'b0;
      else        pixel_q <= pixel_d;
   end

   assign bus.pixel_on = pixel_q;

endmodule

// File: tb/tb_score_display.sv
// Randomised and directed bench for score_display against a
// pixel-arithmetic reference model of the score box.
module tb_score_display;

   typedef struct {
      int h;
      int v;
      bit e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   score_display_if bus ();

   score_display dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   exp_t exp_q[$];
   logic [15:0] snap_m = 16'h0;
   bit tick_m = 1'b0;

   logic [19:0] fnt [10] = '{
      20'hF999F, 20'h26227, 20'hF1F8F, 20'hF171F, 20'h99F11,
      20'hF8F1F, 20'hF8F9F, 20'hF1244, 20'hF9F9F, 20'hF9F1F
   };

   task automatic check(string tag, int got, int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit model_pix(int h, int v, bit de,
                                    logic [15:0] s);
      int rx, k, fc, fr, d, lead;
      if (!de) return 1'b0;
      if (h < 560 || h >= 640 || v < 16 || v >= 36) return 1'b0;
      rx = h - 560;
      k  = rx / 20;
      fc = (rx % 20) / 4;
      fr = (v - 16) / 4;
      if (fc == 4) return 1'b0;
      d = (s >> (4 * (3 - k))) & 15;
      if (d > 9) return 1'b0;
      lead = 0;
      for (int j = 0; j <= k; j++)
         lead += (s >> (4 * (3 - j))) & 15;
      if (k < 3 && lead == 0) return 1'b0;
      return bit'((fnt[d] >> (4 * (4 - fr) + (3 - fc))) & 1);
   endfunction

   task automatic step(int h, int v, bit de, bit tk, logic [15:0] sc);
      exp_t e;
      if (exp_q.size() == 2) begin
         e = exp_q.pop_front();
         check($sformatf("pix h%0d v%0d", e.h, e.v),
               int'(bus.pixel_on), int'(e.e));
      end
      bus.hpos       = 10'(h);
      bus.vpos       = 10'(v);
      bus.display_on = de;
      bus.game_tick  = tk;
      bus.score      = sc;
      e.h = h;
      e.v = v;
      if (rst_n) begin
         if (tick_m) snap_m = sc;
         tick_m = tk;
         e.e = model_pix(h, v, de, snap_m);
      end else begin
         tick_m = 1'b0;
         e.e = 1'b0;
      end
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 1'b0, 1'b0, 16'($urandom));
   endtask

   task automatic sweep(int vs, int ve);
      for (int v = vs; v <= ve; v++)
         for (int h = 556; h <= 643; h++)
            step(h, v, 1'b1, 1'b0, 16'($urandom));
   endtask

   task automatic tick(logic [15:0] sc);
      step(0, 0, 1'b0, 1'b1, sc);
      step(0, 0, 1'b0, 1'b0, sc);
      idle();
   endtask

   // pulse one beam position, confirm it shows up exactly two cycles on
   task automatic probe(string tag, int h, int v, bit de, int exp);
      idle();
      idle();
      step(h, v, de, 1'b0, 16'($urandom));
      check({tag, "_c1"}, int'(bus.pixel_on), 0);
      idle();
      check({tag, "_c2"}, int'(bus.pixel_on), exp);
      idle();
      check({tag, "_c3"}, int'(bus.pixel_on), 0);
   endtask

   function automatic logic [15:0] rand_score();
      logic [15:0] s;
      int r;
      s = 16'h0;
      for (int j = 0; j < 4; j++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3)       s[4*j +: 4] = 4'h0;
         else if (r == 3) s[4*j +: 4] = 4'($urandom_range(10, 15));
         else             s[4*j +: 4] = 4'($urandom_range(1, 9));
      end
      return s;
   endfunction

   initial begin
      bus.hpos       = 10'd0;
      bus.vpos       = 10'd0;
      bus.display_on = 1'b0;
      bus.game_tick  = 1'b0;
      bus.score      = 16'h0;
      @(negedge clk);

      step(0, 0, 1'b0, 1'b1, 16'h4321);
      sweep(16, 35);
      rst_n = 1'b1;
      sweep(16, 35);

      probe("lat", 620, 16, 1'b1, 1);
      probe("de_gate", 620, 16, 1'b0, 0);
      probe("edge_l", 559, 16, 1'b1, 0);
      probe("edge_r", 640, 16, 1'b1, 0);

      tick(16'h1234);
      sweep(16, 35);
      probe("snap_1234", 568, 16, 1'b1, 1);
      probe("row1_1234", 564, 20, 1'b1, 1);

      tick(16'h0050);
      sweep(16, 35);
      tick(16'h1000);
      sweep(16, 35);
      tick(16'h00A5);
      sweep(16, 35);

      step(620, 16, 1'b1, 1'b0, 16'h0);
      step(620, 16, 1'b1, 1'b0, 16'h0);
      step(620, 16, 1'b1, 1'b0, 16'h0);
      check("pre_rst", int'(bus.pixel_on), 1);
      #2 rst_n = 1'b0;
      #1 check("rst_async", int'(bus.pixel_on), 0);
      exp_q.delete();
      snap_m = 16'h0;
      tick_m = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         step(620, 16, 1'b1, 1'b0, 16'h0);
      check("rst_hold", int'(bus.pixel_on), 0);
      rst_n = 1'b1;
      sweep(16, 35);
      probe("post_rst", 620, 16, 1'b1, 1);

      for (int i = 0; i < 5000; i++)
         step(int'($urandom_range(540, 660)), int'($urandom_range(0, 50)),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 49) == 0), rand_score());
      idle();
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
